// File: rtl/request_gate.sv
// Request filter in front of a 3-client arbiter: tracks grant tenure per owner,
// masks a client that holds the grant too long, and keeps sticky statistics.
module request_gate #(
  parameter int MAX_TENURE = 8,
  parameter int HOLDOFF    = 4,
  parameter int STAT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        r_in,
  input  logic [2:0]        g,
  input  logic              clr,
  output logic [2:0]        r_out,
  output logic [2:0]        timeout,
  output logic              err,
  output logic [STAT_W-1:0] gcnt0,
  output logic [STAT_W-1:0] gcnt1,
  output logic [STAT_W-1:0] gcnt2
);

  typedef enum logic [1:0] {IDLE, OWNED, HOLD} state_t;

  localparam logic [7:0]        MaxTenure = 8'(MAX_TENURE);
  localparam logic [7:0]        HoldOff   = 8'(HOLDOFF);
  localparam logic [STAT_W-1:0] CntMax    = '1;

  state_t            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [7:0]        tenure_q, tenure_d;
  logic [7:0]        hold_q, hold_d;
  logic [2:0]        mask_q, mask_d;
  logic [2:0]        timeout_q, timeout_d;
  logic              err_q, err_d;
  logic [STAT_W-1:0] gcnt_q [3];
  logic [STAT_W-1:0] gcnt_d [3];

  logic       gOneHot;
  logic       gMulti;
  logic [1:0] gIdx;
  logic [2:0] ownerHot;
  logic [2:0] incr;
  logic [2:0] timeoutSet;

  assign gOneHot  = (g == 3'b001) || (g == 3'b010) || (g == 3'b100);
  assign gMulti   = (g != 3'b000) && !gOneHot;
  assign gIdx     = g[2] ? 2'd2 : (g[1] ? 2'd1 : 2'd0);
  assign ownerHot = 3'b001 << owner_q;

  // Multi-hot grants freeze the FSM for that cycle; only err reacts.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    tenure_d   = tenure_q;
    hold_d     = hold_q;
    mask_d     = mask_q;
    incr       = 3'b000;
    timeoutSet = 3'b000;
    if (!gMulti) begin
      case (state_q)
        IDLE: begin
          mask_d = 3'b000;
          if (gOneHot) begin
            owner_d  = gIdx;
            tenure_d = 8'd1;
            state_d  = OWNED;
            incr     = g;
          end
        end
        OWNED: begin
          if (g == 3'b000) begin
            tenure_d = 8'd0;
            state_d  = IDLE;
          end else if (g == ownerHot) begin
            tenure_d = tenure_q + 8'd1;
            if (tenure_q + 8'd1 == MaxTenure) begin
              timeoutSet = ownerHot;
              mask_d     = ownerHot;
              hold_d     = HoldOff;
              state_d    = HOLD;
            end
          end else begin
            owner_d  = gIdx;
            tenure_d = 8'd1;
            incr     = g;
          end
        end
        HOLD: begin
          hold_d = hold_q - 8'd1;
          if (hold_q <= 8'd1) begin
            hold_d   = 8'd0;
            mask_d   = 3'b000;
            tenure_d = 8'd0;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Sticky statistics: a set or increment in the same cycle as clr wins.
  always_comb begin
    timeout_d = (clr ? 3'b000 : timeout_q) | timeoutSet;
    err_d     = (clr ? 1'b0 : err_q) | gMulti;
    for (int i = 0; i < 3; i++) begin
      if (incr[i]) begin
        if (clr)                    gcnt_d[i] = {{(STAT_W-1){1'b0}}, 1'b1};
        else if (gcnt_q[i] == CntMax) gcnt_d[i] = gcnt_q[i];
        else                        gcnt_d[i] = gcnt_q[i] + 1'b1;
      end else begin
        gcnt_d[i] = clr ? '0 : gcnt_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 2'd0;
      tenure_q  <= 8'd0;
      hold_q    <= 8'd0;
      mask_q    <= 3'b000;
      timeout_q <= 3'b000;
      err_q     <= 1'b0;
      gcnt_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      tenure_q  <= tenure_d;
      hold_q    <= hold_d;
      mask_q    <= mask_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      gcnt_q    <= gcnt_d;
    end
  end

  assign r_out   = r_in & ~mask_q;
  assign timeout = timeout_q;
  assign err     = err_q;
  assign gcnt0   = gcnt_q[0];
  assign gcnt1   = gcnt_q[1];
  assign gcnt2   = gcnt_q[2];

endmodule

// File: tb/tb_request_gate.sv
// Directed bench for request_gate with MAX_TENURE=4, HOLDOFF=3, STAT_W=8;
// outputs are sampled 1 time unit after each rising edge.
module tb_request_gate;

  logic       clk;
  logic       reset;
  logic [2:0] rIn;
  logic [2:0] gIn;
  logic       clr;
  logic [2:0] rOut;
  logic [2:0] timeoutO;
  logic       errO;
  logic [7:0] gcnt0, gcnt1, gcnt2;

  int assertCount = 0;
  int failCount   = 0;

  request_gate #(.MAX_TENURE(4), .HOLDOFF(3), .STAT_W(8)) dut (
    .clk(clk), .reset(reset), .r_in(rIn), .g(gIn), .clr(clr),
    .r_out(rOut), .timeout(timeoutO), .err(errO),
    .gcnt0(gcnt0), .gcnt1(gcnt1), .gcnt2(gcnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic [2:0] r, input logic [2:0] gv, input logic c);
    rIn = r;
    gIn = gv;
    clr = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkCounts(input string tag, input int c0, input int c1, input int c2);
    checkOutput({tag, "_gcnt0"}, 32'(gcnt0), 32'(c0));
    checkOutput({tag, "_gcnt1"}, 32'(gcnt1), 32'(c1));
    checkOutput({tag, "_gcnt2"}, 32'(gcnt2), 32'(c2));
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(3'b101, 3'b000, 1'b0);
    tick();
    tick();
    checkOutput("reset_rout", 32'(rOut), 32'h5);
    checkOutput("reset_timeout", 32'(timeoutO), 32'h0);
    checkOutput("reset_err", 32'(errO), 32'h0);
    checkCounts("reset", 0, 0, 0);
    reset = 1'b0;

    // Normal tenure on client 0
    applyStimulus(3'b001, 3'b001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("normal_rout", 32'(rOut), 32'h1);
    end
    applyStimulus(3'b001, 3'b000, 1'b0);
    tick();
    checkOutput("normal_rout_end", 32'(rOut), 32'h1);
    checkOutput("normal_timeout", 32'(timeoutO), 32'h0);
    checkCounts("normal", 1, 0, 0);

    applyStimulus(3'b001, 3'b000, 1'b1);
    tick();
    applyStimulus(3'b101, 3'b100, 1'b0);
    checkCounts("clr1", 0, 0, 0);

    // Client 2 overstays while client 0 also requests
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("tmo_rout_pre", 32'(rOut), 32'h5);
    end
    tick();
    checkOutput("tmo_rout_hold1", 32'(rOut), 32'h1);
    checkOutput("tmo_timeout", 32'(timeoutO), 32'h4);
    checkCounts("tmo_entry", 0, 0, 1);
    applyStimulus(3'b101, 3'b001, 1'b0);
    tick();
    checkOutput("tmo_rout_hold2", 32'(rOut), 32'h1);
    tick();
    checkOutput("tmo_rout_hold3", 32'(rOut), 32'h1);
    checkOutput("tmo_hold_gcnt0", 32'(gcnt0), 32'h0);
    tick();
    checkOutput("tmo_rout_exit", 32'(rOut), 32'h5);
    checkOutput("tmo_exit_gcnt0", 32'(gcnt0), 32'h0);
    tick();
    checkCounts("tmo_after", 1, 0, 1);
    checkOutput("tmo_timeout_sticky", 32'(timeoutO), 32'h4);
    applyStimulus(3'b101, 3'b000, 1'b0);
    tick();

    applyStimulus(3'b101, 3'b000, 1'b1);
    tick();
    applyStimulus(3'b110, 3'b010, 1'b0);
    checkOutput("clr2_timeout", 32'(timeoutO), 32'h0);
    checkCounts("clr2", 0, 0, 0);

    // Owner switch lands exactly where the old tenure would have timed out
    tick();
    tick();
    tick();
    applyStimulus(3'b110, 3'b100, 1'b0);
    tick();
    checkOutput("switch_rout", 32'(rOut), 32'h6);
    checkOutput("switch_timeout", 32'(timeoutO), 32'h0);
    tick();
    tick();
    applyStimulus(3'b110, 3'b000, 1'b0);
    tick();
    checkOutput("switch_end_timeout", 32'(timeoutO), 32'h0);
    checkOutput("switch_end_rout", 32'(rOut), 32'h6);
    checkCounts("switch", 0, 1, 1);

    // Protocol error, then clr coincident with a new tenure start
    applyStimulus(3'b011, 3'b011, 1'b0);
    tick();
    checkOutput("perr_err", 32'(errO), 32'h1);
    checkCounts("perr", 0, 1, 1);
    applyStimulus(3'b011, 3'b000, 1'b0);
    tick();
    checkOutput("perr_sticky", 32'(errO), 32'h1);
    applyStimulus(3'b011, 3'b001, 1'b1);
    tick();
    checkOutput("clrstart_err", 32'(errO), 32'h0);
    checkOutput("clrstart_timeout", 32'(timeoutO), 32'h0);
    checkCounts("clrstart", 1, 0, 0);
    applyStimulus(3'b011, 3'b000, 1'b0);
    tick();

    // Saturation of gcnt0 after 260 short tenures
    for (int i = 0; i < 260; i++) begin
      applyStimulus(3'b001, 3'b001, 1'b0);
      tick();
      applyStimulus(3'b001, 3'b000, 1'b0);
      tick();
    end
    checkOutput("sat_gcnt0", 32'(gcnt0), 32'hFF);

    // Reset on the second HOLD cycle
    applyStimulus(3'b100, 3'b100, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("rsthold_rout", 32'(rOut), 32'h0);
    checkOutput("rsthold_timeout", 32'(timeoutO), 32'h4);
    applyStimulus(3'b100, 3'b000, 1'b0);
    tick();
    checkOutput("rsthold_rout2", 32'(rOut), 32'h0);
    reset = 1'b1;
    tick();
    checkOutput("rsthold_rout_rst", 32'(rOut), 32'h4);
    checkOutput("rsthold_timeout_rst", 32'(timeoutO), 32'h0);
    checkOutput("rsthold_err_rst", 32'(errO), 32'h0);
    checkCounts("rsthold", 0, 0, 0);
    reset = 1'b0;
    tick();
    checkOutput("rsthold_rout_after", 32'(rOut), 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/request_gate.md
REQUEST_GATE -- requirements
Module: request_gate

Interface
REQ-001 Parameter MAX_TENURE, default 8, maximum consecutive grant cycles allowed to one client; legal range 2..255.
REQ-002 Parameter HOLDOFF, default 4, cycles an over-tenure client is masked after timeout; legal range 1..255.
REQ-003 Parameter STAT_W, default 8, width of each per-client grant counter.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 r_in  in  3  raw client requests; bit 2 is the highest priority.
REQ-007 g  in  3  grant vector returned by the downstream arbiter; one-hot or zero.
REQ-008 clr  in  1  single-cycle pulse that clears sticky flags and counters.
REQ-009 r_out  out  3  filtered requests driven to the arbiter's r input.
REQ-010 timeout  out  3  sticky per-client tenure-violation flags.
REQ-011 err  out  1  sticky flag for a protocol error on g.
REQ-012 gcnt0/gcnt1/gcnt2  out  STAT_W each  saturating per-client tenure-start counters.

Function
REQ-013 r_out SHALL equal r_in & ~mask, combinationally with zero latency; mask is a registered 3-bit value.
REQ-014 FSM states SHALL be IDLE, OWNED and HOLD. State, owner index (2 bits), tenure_cnt and hold_cnt SHALL all be registered.
REQ-015 IDLE: mask = 0. On a one-hot g -> owner = index of g, tenure_cnt = 1, next state OWNED, and gcnt[owner] increments.
REQ-016 OWNED, when g == onehot(owner) -> tenure_cnt increments.
REQ-017 OWNED, when tenure_cnt reaches MAX_TENURE on that update -> set timeout[owner], mask = onehot(owner), hold_cnt = HOLDOFF, next state HOLD.
REQ-018 OWNED, when g == 0 -> next state IDLE and tenure_cnt = 0.
REQ-019 OWNED, when g changes to a different one-hot value -> owner = new index, tenure_cnt = 1, stay in OWNED, and gcnt[new] increments.
REQ-020 HOLD: mask stays onehot(owner) and hold_cnt decrements each cycle.
REQ-021 HOLD, on the cycle hold_cnt == 1 -> mask = 0, tenure_cnt = 0, next state IDLE; the mask is therefore active for exactly HOLDOFF cycles.
REQ-022 Grants seen during HOLD SHALL NOT be tenure-tracked or counted. A grant still present on IDLE entry SHALL start a new tenure in the following cycle per REQ-015.
REQ-023 A g with more than one bit set SHALL set err in any state, leave the state unchanged for that cycle and increment no counter.
REQ-024 gcnt SHALL saturate at 2^STAT_W-1 and never wrap.
REQ-025 clr SHALL zero timeout, err and all gcnt in the next cycle. It SHALL NOT affect FSM state, mask or the counters internal to the FSM.
REQ-026 If clr and a set or increment occur in the same cycle, the set or increment wins: the flag ends at 1 and the counter ends at 1.
REQ-027 A tenure reaching MAX_TENURE in the same cycle that g changes owner SHALL follow REQ-019; no timeout is flagged.

Reset
REQ-028 When reset = 1 at a rising edge, the block SHALL enter IDLE with mask = 0, owner = 0, tenure_cnt = 0, hold_cnt = 0, timeout = 0, err = 0 and gcnt0..2 = 0.
REQ-029 During and after reset, r_out SHALL equal r_in, because mask = 0.
REQ-030 Reset asserted mid-OWNED or mid-HOLD SHALL abort the tenure or holdoff immediately. No timeout is flagged for the aborted tenure.
REQ-031 Reset SHALL take priority over clr and over every FSM transition.

Verification (MAX_TENURE=4, HOLDOFF=3, STAT_W=8)
REQ-032 Normal tenure: r_in=001, g=001 for 3 cycles, then g=000 -> gcnt0=1, timeout=000, r_out=001 throughout, state returns to IDLE.
REQ-033 Timeout: r_in=100 held, g=100 for 4 cycles -> timeout=100; r_out=000 for exactly 3 cycles, then 100; gcnt2=1.
REQ-034 Masking while others request: r_in=101 with g=100 held to timeout -> r_out=001 for 3 cycles; g=001 during HOLD is not counted (gcnt0=0); gcnt0=1 one cycle after HOLD exits if g=001 persists.
REQ-035 Owner switch: g=010 for 3 cycles, then g=100 for 3 cycles, then 000 -> gcnt1=1, gcnt2=1, timeout=000.
REQ-036 Protocol error and clear: g=011 for one cycle -> err=1 with gcnt unchanged; clr pulse -> err=0, timeout=000 and gcnt=0 next cycle; clr coincident with a new tenure start -> that gcnt=1.
REQ-037 Reset mid-HOLD: reset asserted on the 2nd HOLD cycle -> next cycle r_out=r_in, timeout=000, err=0, all gcnt=0.
